fifo_readout_framer: RTL and testbench
======================================

Name: fifo_readout_framer

Overview:
Drains the 32-bit check-data FIFO that the data checker/aggregator stage produces and packs it into framed records for the host readout path. The FIFO side is the fifo_dout/fifo_empty/fifo_rd_en interface; the output side is a valid/ready word stream. Each frame has one header word, up to FRAME_WORDS payload words and one trailer word. A frame closes early on an idle timeout so that low-rate error records are not held back.

Parameters:
FRAME_WORDS, 64, maximum payload words per frame (1..255)
TIMEOUT, 1024, idle cycles with no payload available before a partial frame is closed (>=2)
HDR_TAG, 16'hA5C3, header tag in bits [31:16]
TRL_TAG, 8'h5A, trailer tag in bits [31:24]

Ports:
clock  input  1  readout clock; the same clock drives the FIFO read side (fifo_rd_clk)
reset  input  1  asynchronous, active-high
enable  input  1  when 1, permits a new frame to start
fifo_dout  input  32  FIFO read data; valid exactly 1 cycle after fifo_rd_en (standard, non-FWFT)
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  FIFO read strobe
out_data  output  32  framed word
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts the word when out_valid && out_ready
out_last  output  1  marks the trailer word
frame_count  output  16  number of frames completed, wraps
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE. fifo_rd_en, out_valid, out_last, busy = 0. out_data, frame_count, payload count, checksum, timeout counter, buffer occupancy and in-flight flag = 0.
- FSM states: IDLE, HEADER, PAYLOAD, TRAILER.
- IDLE -> HEADER when enable && !fifo_empty. Clear payload count and checksum on this transition.
- HEADER: out_data={HDR_TAG, frame_count}, out_valid=1. On handshake -> PAYLOAD.
- PAYLOAD buffer: 2-entry buffer plus one in-flight read flag.
  - fifo_rd_en=1 when all hold: !fifo_empty, occupancy+inflight<2, and count_sent+occupancy+inflight<FRAME_WORDS.
  - Never over-read past the frame boundary. Never read in any state other than PAYLOAD.
  - The word returned 1 cycle after fifo_rd_en is written to the buffer tail.
- PAYLOAD output: out_valid = buffer non-empty; out_data = buffer head.
  - On each handshake: count+1, checksum ^= data[31:16]^data[15:0].
  - Sustained throughput is 1 word/cycle when the FIFO is not empty and out_ready=1.
- PAYLOAD exits:
  - -> TRAILER when count==FRAME_WORDS, buffer empty and no read in flight.
  - -> TRAILER on timeout: the timeout counter increments each cycle that fifo_empty && buffer empty && !inflight, and clears otherwise. When it reaches TIMEOUT-1, go to TRAILER (count>=1 is guaranteed because HEADER is entered only with data present).
- TRAILER: out_data={TRL_TAG, count[7:0], checksum16}, out_valid=1, out_last=1. On handshake: frame_count+1 (wraps 0xFFFF->0) and -> IDLE.
- enable deasserted mid-frame has no effect; the current frame completes normally.
- out_data/out_valid hold stable while out_valid && !out_ready (AXI-stream rule). fifo_empty rising while a read is in flight does not cancel that read.
- Back-to-back frames: IDLE->HEADER may occur on the cycle after the trailer handshake, so there is a minimum 1 idle cycle between frames.
- Reset asserted mid-frame aborts immediately; any partially emitted frame is discarded by the consumer. Words already read from the FIFO are lost.

Decomposition:
- Shared package (readout_pkg): state encoding localparams (IDLE=2'd0, HEADER=2'd1, PAYLOAD=2'd2, TRAILER=2'd3), HDR_TAG/TRL_TAG defaults, checksum fold function.
- One sub-module: readout_skid_buf (2-entry buffer with in-flight tracking, occupancy outputs); the FSM and counters stay in the top.

Test Plan:
- FIFO preloaded with 64 words 0x00000001..0x00000040, out_ready=1, enable=1 -> A5C30000, 64 payload words in order with no gaps after the first, trailer 5A40xxxx with checksum = XOR fold of those 64 words; frame_count=1; fifo_rd_en pulsed exactly 64 times.
- FIFO holds 3 words (0xDEADBEEF, 0x12345678, 0xCAFEF00D) then stays empty -> header, 3 words, trailer 5A03 + checksum16 emitted exactly TIMEOUT cycles after the buffer drains; out_last=1 only on the trailer.
- 130 words preloaded, FRAME_WORDS=64 -> frames 0 and 1 full (count 0x40), frame 2 closes on timeout with count 0x02; headers carry 0000, 0001, 0002; no word lost or duplicated.
- Random out_ready (50%) with a full FIFO -> out_data stable while stalled, occupancy never exceeds 2, payload sequence identical to the out_ready=1 run.
- enable dropped on the 10th payload word -> frame still completes with 64 words; no new header while enable=0 even though the FIFO is non-empty.
- reset pulsed mid-PAYLOAD -> all outputs 0 on the same edge (asynchronous), frame_count=0, next frame header is A5C30000.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared definitions for the FIFO readout framer.
//   state_e          : framer FSM state encoding
//   HDR_TAG_DEFAULT  : default header tag, placed in header bits [31:16]
//   TRL_TAG_DEFAULT  : default trailer tag, placed in trailer bits [31:24]
//   csum_fold()      : folds a 32-bit payload word into the 16-bit running checksum
package readout_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHeader  = 2'd1,
        StPayload = 2'd2,
        StTrailer = 2'd3
    } state_e;

    localparam logic [15:0] HDR_TAG_DEFAULT = 16'hA5C3;
    localparam logic [7:0]  TRL_TAG_DEFAULT = 8'h5A;

    function automatic logic [15:0] csum_fold(input logic [31:0] word);
        return word[31:16] ^ word[15:0];
    endfunction

endpackage

// File: rtl/readout_skid_buf.sv
// Two-entry payload buffer sitting behind a non-FWFT FIFO read port.
//   clock, reset : clock and asynchronous active-high reset
//   rd_issue     : a FIFO read strobe is being issued this cycle
//   rd_data      : FIFO read data, valid the cycle after rd_issue
//   pop          : head entry is consumed this cycle
//   head         : oldest buffered word
//   occupancy    : number of buffered words (0..2)
//   inflight     : a read was issued last cycle and its data lands this cycle
module readout_skid_buf (
    input  logic        clock,
    input  logic        reset,
    input  logic        rd_issue,
    input  logic [31:0] rd_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic [1:0]  occupancy,
    output logic        inflight
);

    logic [31:0] ent0_q, ent1_q;
    logic [1:0]  occ_q;
    logic        inflight_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent0_q     <= '0;
            ent1_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_issue;
            // ent0 is always the head; ent1 only holds data when occ_q == 2.
            case ({inflight_q, pop})
                2'b10: begin
                    if (occ_q == 2'd0) ent0_q <= rd_data;
                    else               ent1_q <= rd_data;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        ent0_q <= ent1_q;
                        ent1_q <= rd_data;
                    end else begin
                        ent0_q <= rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head      = ent0_q;
    assign occupancy = occ_q;
    assign inflight  = inflight_q;

endmodule

// File: rtl/fifo_readout_framer.sv
// Drains a 32-bit non-FWFT FIFO into framed records: header, up to FRAME_WORDS payload words,
// trailer. A partial frame closes after TIMEOUT idle cycles.
//   clock, reset          : clock and asynchronous active-high reset
//   enable                : allows a new frame to start
//   fifo_dout, fifo_empty : FIFO read data (1-cycle latency) and empty flag
//   fifo_rd_en            : FIFO read strobe
//   out_data/out_valid/out_ready/out_last : framed word stream, out_last marks the trailer
//   frame_count           : completed frames, wrapping
//   busy                  : FSM not idle
module fifo_readout_framer
    import readout_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = 64,
    parameter int unsigned TIMEOUT     = 1024,
    parameter logic [15:0] HDR_TAG     = HDR_TAG_DEFAULT,
    parameter logic [7:0]  TRL_TAG     = TRL_TAG_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam int unsigned TmoW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e          state_q, state_d;
    logic [7:0]      count_q, count_d;
    logic [15:0]     csum_q, csum_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [15:0]     fcount_q, fcount_d;

    logic [31:0] buf_head;
    logic [1:0]  buf_occ;
    logic        buf_inflight;
    logic [1:0]  pending;
    logic        pop;
    logic        drained;

    readout_skid_buf u_buf (
        .clock     (clock),
        .reset     (reset),
        .rd_issue  (fifo_rd_en),
        .rd_data   (fifo_dout),
        .pop       (pop),
        .head      (buf_head),
        .occupancy (buf_occ),
        .inflight  (buf_inflight)
    );

    assign pending = buf_occ + {1'b0, buf_inflight};
    assign drained = (buf_occ == 2'd0) && !buf_inflight;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        csum_d     = csum_q;
        tmo_d      = '0;
        fcount_d   = fcount_q;
        out_data   = '0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        fifo_rd_en = 1'b0;
        pop        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable && !fifo_empty) begin
                    state_d = StHeader;
                    count_d = '0;
                    csum_d  = '0;
                end
            end
            StHeader: begin
                out_data  = {HDR_TAG, fcount_q};
                out_valid = 1'b1;
                if (out_ready) state_d = StPayload;
            end
            StPayload: begin
                out_valid = (buf_occ != 2'd0);
                out_data  = buf_head;
                pop       = out_valid && out_ready;
                if (pop) begin
                    count_d = count_q + 8'd1;
                    csum_d  = csum_q ^ csum_fold(buf_head);
                end
                // A same-cycle pop frees a slot, which keeps one word per cycle flowing.
                // count + pending is invariant under a pop, so the frame limit uses pre-pop values.
                fifo_rd_en = !fifo_empty && ((pending != 2'd2) || pop) &&
                             (({1'b0, count_q} + {7'b0, pending}) < 9'(FRAME_WORDS));
                if (drained && (32'(count_q) == FRAME_WORDS)) begin
                    state_d = StTrailer;
                end else if (drained && fifo_empty) begin
                    tmo_d = tmo_q + TmoW'(1);
                    // Leave on the edge where the counter reaches TIMEOUT-1.
                    if (tmo_q == TmoW'(TIMEOUT - 2)) state_d = StTrailer;
                end
            end
            StTrailer: begin
                out_data  = {TRL_TAG, count_q, csum_q};
                out_valid = 1'b1;
                out_last  = 1'b1;
                if (out_ready) begin
                    fcount_d = fcount_q + 16'd1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            count_q  <= '0;
            csum_q   <= '0;
            tmo_q    <= '0;
            fcount_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            csum_q   <= csum_d;
            tmo_q    <= tmo_d;
            fcount_q <= fcount_d;
        end
    end

    assign frame_count = fcount_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_readout_framer.sv
// Bench for fifo_readout_framer: a behavioural FIFO feeds the DUT, a monitor records every
// accepted output word, and a frame-level model predicts the word stream from the loaded data.
module tb_fifo_readout_framer;

    localparam int unsigned FW  = 64;
    localparam int unsigned TMO = 40;

    logic        clock      = 1'b0;
    logic        reset      = 1'b1;
    logic        enable     = 1'b0;
    logic [31:0] fifo_dout  = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready  = 1'b1;
    logic        out_last;
    logic [15:0] frame_count;
    logic        busy;

    always #5 clock = ~clock;

    fifo_readout_framer #(
        .FRAME_WORDS (FW),
        .TIMEOUT     (TMO)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .fifo_dout   (fifo_dout),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .frame_count (frame_count),
        .busy        (busy)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0] fifo_q[$];
    logic [31:0] src[$];
    logic [31:0] exp_d[$];
    logic        exp_l[$];
    logic [31:0] got_d[$];
    logic        got_l[$];
    int          got_c[$];
    logic [15:0] exp_fc     = '0;
    int          rd_count   = 0;
    int          pay_total  = 0;
    int          occ_max    = 0;
    int          underflow  = 0;
    bit          hdr_next   = 1'b1;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    bit          stall_chk  = 1'b0;
    bit          rand_ready = 1'b0;
    logic        rd_s;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    // Non-FWFT FIFO: data for a strobe seen in one cycle appears just after the next edge.
    initial begin
        forever begin
            @(negedge clock);
            rd_s = fifo_rd_en;
            @(posedge clock);
            #1;
            if (rd_s && !reset) begin
                if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
                else underflow++;
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor, sampling mid-cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                hdr_next   = 1'b1;
                prev_stall = 1'b0;
            end else begin
                if (rd_count - pay_total > occ_max) occ_max = rd_count - pay_total;
                if (fifo_rd_en) rd_count++;
                if (stall_chk && prev_stall) begin
                    check_eq("stall_valid", 32'(out_valid), 32'd1);
                    check_eq("stall_data", out_data, prev_data);
                end
                if (out_valid && out_ready) begin
                    got_d.push_back(out_data);
                    got_l.push_back(out_last);
                    got_c.push_back(cyc);
                    if (hdr_next) hdr_next = 1'b0;
                    else if (out_last) hdr_next = 1'b1;
                    else pay_total++;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_test();
        got_d.delete(); got_l.delete(); got_c.delete();
        exp_d.delete(); exp_l.delete(); src.delete();
        rd_count  = 0;
        pay_total = 0;
        occ_max   = 0;
    endtask

    task automatic push_word(input logic [31:0] w);
        src.push_back(w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic load_words(input int n, input bit rnd);
        for (int i = 0; i < n; i++) push_word(rnd ? 32'($urandom) : 32'(i + 1));
    endtask

    // Frame model: the first n words of src, split into frames of at most FW words.
    task automatic expect_frames(input int n);
        int          idx;
        int          len;
        logic [15:0] sum;
        logic [31:0] w;
        idx = 0;
        while (idx < n) begin
            len = (n - idx > int'(FW)) ? int'(FW) : n - idx;
            sum = '0;
            exp_d.push_back({16'hA5C3, exp_fc});
            exp_l.push_back(1'b0);
            for (int k = 0; k < len; k++) begin
                w = src[idx + k];
                exp_d.push_back(w);
                exp_l.push_back(1'b0);
                sum = sum ^ w[31:16] ^ w[15:0];
            end
            exp_d.push_back({8'h5A, 8'(len), sum});
            exp_l.push_back(1'b1);
            exp_fc = exp_fc + 16'd1;
            idx    = idx + len;
        end
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int i = 0; i < budget && got_d.size() < n; i++) step();
    endtask

    task automatic compare_stream(input string tag);
        check_eq({tag, "_len"}, 32'(got_d.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            check_eq($sformatf("%s_w%0d", tag, i), got_d[i], exp_d[i]);
            check_eq($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(exp_l[i]));
        end
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        repeat (2) step();
        reset  = 1'b0;
        exp_fc = '0;
    endtask

    initial begin
        int gaps;

        // Reset state.
        repeat (3) step();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check_eq("rst_last", 32'(out_last), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_data", out_data, 32'd0);
        check_eq("rst_fcount", 32'(frame_count), 32'd0);
        reset = 1'b0;
        step();

        // Full frame of 1..64 at full rate.
        start_test();
        load_words(64, 1'b0);
        expect_frames(64);
        enable = 1'b1;
        wait_words(exp_d.size(), 400);
        compare_stream("t1");
        if (got_c.size() >= 66) begin
            gaps = 0;
            for (int i = 1; i < 64; i++) if (got_c[i + 1] - got_c[i] != 1) gaps++;
            check_eq("t1_gaps", 32'(gaps), 32'd0);
        end
        repeat (3) step();
        check_eq("t1_rd_count", 32'(rd_count), 32'd64);
        check_eq("t1_fcount", 32'(frame_count), 32'(exp_fc));

        // Three words then an empty FIFO: trailer after the idle timeout.
        start_test();
        push_word(32'hDEADBEEF);
        push_word(32'h12345678);
        push_word(32'hCAFEF00D);
        expect_frames(3);
        wait_words(exp_d.size(), TMO + 100);
        compare_stream("t2");
        if (got_c.size() >= 5) check_eq("t2_tmo_gap", 32'(got_c[4] - got_c[3]), 32'(TMO));
        repeat (3) step();
        check_eq("t2_fcount", 32'(frame_count), 32'(exp_fc));

        // 130 words: two full frames and a timed-out partial.
        do_reset();
        start_test();
        load_words(130, 1'b1);
        expect_frames(130);
        wait_words(exp_d.size(), 600 + TMO);
        compare_stream("t3");
        repeat (3) step();
        check_eq("t3_fcount", 32'(frame_count), 32'(exp_fc));
        check_eq("t3_rd_count", 32'(rd_count), 32'd130);

        // Random back-pressure.
        start_test();
        stall_chk  = 1'b1;
        rand_ready = 1'b1;
        load_words(128, 1'b1);
        expect_frames(128);
        wait_words(exp_d.size(), 3000);
        rand_ready = 1'b0;
        stall_chk  = 1'b0;
        compare_stream("t4");
        check_eq("t4_occ_le2", 32'(occ_max <= 2), 32'd1);
        repeat (3) step();
        check_eq("t4_fcount", 32'(frame_count), 32'(exp_fc));

        // Enable dropped mid-frame: frame completes, no new frame starts.
        start_test();
        load_words(70, 1'b1);
        expect_frames(64);
        for (int i = 0; i < 200 && pay_total < 10; i++) step();
        enable = 1'b0;
        wait_words(exp_d.size(), 400);
        repeat (50) step();
        compare_stream("t5");
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_fcount", 32'(frame_count), 32'(exp_fc));

        // Asynchronous reset in the middle of a payload.
        start_test();
        enable = 1'b1;
        for (int i = 0; i < 200 && pay_total < 2; i++) step();
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_rd_en", 32'(fifo_rd_en), 32'd0);
        check_eq("arst_last", 32'(out_last), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_data", out_data, 32'd0);
        check_eq("arst_fcount", 32'(frame_count), 32'd0);
        fifo_q.delete();
        fifo_empty = 1'b1;
        repeat (2) step();
        reset  = 1'b0;
        exp_fc = '0;
        step();
        start_test();
        push_word(32'h0BAD_F00D);
        push_word(32'h7777_1234);
        expect_frames(2);
        wait_words(exp_d.size(), TMO + 100);
        compare_stream("t6");

        check_eq("fifo_underflow", 32'(underflow), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
